// File: rtl/fwd_hazard_ctrl_pkg.sv
// rtl/fwd_hazard_ctrl_pkg.sv - shared select encoding and slot match helper for fwd_hazard_ctrl
package fwd_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_REG    = 2'b00,
        FWD_EX_MEM = 2'b01,
        FWD_MEM_WB = 2'b10
    } fwd_sel_e;

    // A slot supplies a source when it holds a real writer of that register and the
    // register is not the hard-wired zero register.
    function automatic logic slot_writes(input logic valid, input logic wr_en,
                                         input logic rd_match, input logic src_is_zero);
        return valid & wr_en & rd_match & ~src_is_zero;
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// rtl/fwd_src_match.sv - per-operand producer match (select and hazard hit), FORWARDING_EN aware
module fwd_src_match
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    input  logic              ex_valid,
    input  logic              ex_wr_en,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_valid,
    input  logic              mem_wr_en,
    input  logic [REG_AW-1:0] mem_rd,
    output logic [1:0]        sel,
    output logic              load_hit
);

    localparam logic [REG_AW-1:0] ZERO_REG = '1;

    logic ex_hit;
    logic mem_hit;
    logic ex_alu_hit;
    logic ex_load_hit;

    // Classify the newest producer of this source (EX beats MEM).
    always_comb begin
        ex_hit      = used & slot_writes(ex_valid, ex_wr_en, ex_rd == src, src == ZERO_REG);
        mem_hit     = used & slot_writes(mem_valid, mem_wr_en, mem_rd == src, src == ZERO_REG);
        ex_alu_hit  = ex_hit & ~ex_is_load;
        ex_load_hit = ex_hit & ex_is_load;
        sel         = FWD_REG;
`ifdef FORWARDING_EN
        if (ex_alu_hit) begin
            sel = FWD_EX_MEM;
        end else if (mem_hit) begin
            sel = FWD_MEM_WB;
        end
        load_hit = ex_load_hit;
`else
        // No bypass paths: any producer still in EX or MEM must reach WB first.
        load_hit = ex_alu_hit | ex_load_hit | mem_hit;
`endif
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - forwarding/hazard controller top; FORWARDING_EN enables bypass selects
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_rn_used,
    input  logic              id_rm_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              mem_ready,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              flush_ex
);

    // Shadow slots. A WB-stage writer needs no action because the register file
    // writes through in the same cycle, so only EX and MEM are tracked; is_load
    // only matters while the producer sits in EX.
    logic              ex_valid;
    logic              ex_wr_en;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_valid;
    logic              mem_wr_en;
    logic [REG_AW-1:0] mem_rd;

    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic       a_hit;
    logic       b_hit;
    logic       load_use;
    logic       issue;

    fwd_src_match #(.REG_AW(REG_AW)) u_match_a (
        .src        (id_rn),
        .used       (id_valid & id_rn_used),
        .ex_valid   (ex_valid),
        .ex_wr_en   (ex_wr_en),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .mem_valid  (mem_valid),
        .mem_wr_en  (mem_wr_en),
        .mem_rd     (mem_rd),
        .sel        (a_sel),
        .load_hit   (a_hit)
    );

    fwd_src_match #(.REG_AW(REG_AW)) u_match_b (
        .src        (id_rm),
        .used       (id_valid & id_rm_used),
        .ex_valid   (ex_valid),
        .ex_wr_en   (ex_wr_en),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .mem_valid  (mem_valid),
        .mem_wr_en  (mem_wr_en),
        .mem_rd     (mem_rd),
        .sel        (b_sel),
        .load_hit   (b_hit)
    );

    // Front-end controls; both forced low while reset is held.
    always_comb begin
        load_use = a_hit | b_hit;
        issue    = id_valid & ~load_use;
        stall    = ~rst & (load_use | ~mem_ready);
        flush_ex = ~rst & load_use & mem_ready;
    end

    // Advance the shadow pipeline and select registers only when memory completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_wr_en   <= 1'b0;
            ex_is_load <= 1'b0;
            ex_rd      <= '0;
            mem_valid  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_rd     <= '0;
            fwd_a_sel  <= FWD_REG;
            fwd_b_sel  <= FWD_REG;
        end else if (mem_ready) begin
            mem_valid  <= ex_valid;
            mem_wr_en  <= ex_wr_en;
            mem_rd     <= ex_rd;
            ex_valid   <= issue;
            ex_wr_en   <= id_wr_en;
            ex_is_load <= id_is_load;
            ex_rd      <= id_rd;
            fwd_a_sel  <= issue ? a_sel : FWD_REG;
            fwd_b_sel  <= issue ? b_sel : FWD_REG;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed self-checking bench for fwd_hazard_ctrl (both FORWARDING_EN builds)
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_rn_used;
    logic       id_rm_used;
    logic [4:0] id_rd;
    logic       id_wr_en;
    logic       id_is_load;
    logic       mem_ready;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;
    logic       flush_ex;

    int errors = 0;
    int checks = 0;

    fwd_hazard_ctrl #(.REG_AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rn      (id_rn),
        .id_rm      (id_rm),
        .id_rn_used (id_rn_used),
        .id_rm_used (id_rm_used),
        .id_rd      (id_rd),
        .id_wr_en   (id_wr_en),
        .id_is_load (id_is_load),
        .mem_ready  (mem_ready),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall      (stall),
        .flush_ex   (flush_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                          input logic [4:0] rn, input logic rnu, input logic [4:0] rm, input logic rmu);
        id_valid   = v;
        id_rd      = rd;
        id_wr_en   = wr;
        id_is_load = ld;
        id_rn      = rn;
        id_rn_used = rnu;
        id_rm      = rm;
        id_rm_used = rmu;
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        mem_ready = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        mem_ready = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall_gated: got %b want 0", stall); end
        do_reset;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
        checks++; if (flush_ex !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", flush_ex); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL rst_a_sel: got %b want 00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL rst_b_sel: got %b want 00", fwd_b_sel); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        set_id(1, 1, 1, 0, 2, 1, 3, 1);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_prod_stall: got %b want 0", stall); end
        tick;
        set_id(1, 2, 1, 0, 1, 1, 3, 1);
`ifdef FORWARDING_EN
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b want 0", stall); end
        tick;
        checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL b2b_a_sel: got %b want 01", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL b2b_b_sel: got %b want 00", fwd_b_sel); end
`else
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall1: got %b want 1", stall); end
        checks++; if (flush_ex !== 1'b1) begin errors++; $display("FAIL b2b_flush1: got %b want 1", flush_ex); end
        tick;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall2: got %b want 1", stall); end
        checks++; if (flush_ex !== 1'b1) begin errors++; $display("FAIL b2b_flush2: got %b want 1", flush_ex); end
        tick;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall3: got %b want 0", stall); end
        tick;
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL b2b_a_sel: got %b want 00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL b2b_b_sel: got %b want 00", fwd_b_sel); end
`endif
    endtask

    task automatic test_distance2;
        do_reset;
        set_id(1, 1, 1, 0, 2, 1, 3, 1);
        tick;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        set_id(1, 4, 1, 0, 5, 1, 1, 1);
`ifdef FORWARDING_EN
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL d2_stall: got %b want 0", stall); end
        tick;
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL d2_a_sel: got %b want 00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL d2_b_sel: got %b want 10", fwd_b_sel); end
`else
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL d2_stall1: got %b want 1", stall); end
        checks++; if (flush_ex !== 1'b1) begin errors++; $display("FAIL d2_flush1: got %b want 1", flush_ex); end
        tick;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL d2_stall2: got %b want 0", stall); end
        tick;
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL d2_b_sel: got %b want 00", fwd_b_sel); end
`endif
    endtask

    task automatic test_load_use;
        do_reset;
        set_id(1, 7, 1, 1, 2, 1, 0, 0);
        tick;
        set_id(1, 8, 1, 0, 7, 1, 7, 1);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall1: got %b want 1", stall); end
        checks++; if (flush_ex !== 1'b1) begin errors++; $display("FAIL lu_flush1: got %b want 1", flush_ex); end
        tick;
`ifdef FORWARDING_EN
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall2: got %b want 0", stall); end
        checks++; if (flush_ex !== 1'b0) begin errors++; $display("FAIL lu_flush2: got %b want 0", flush_ex); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL lu_bubble_sel: got %b want 00", fwd_a_sel); end
        tick;
        checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL lu_a_sel: got %b want 10", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL lu_b_sel: got %b want 10", fwd_b_sel); end
`else
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall2: got %b want 1", stall); end
        tick;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall3: got %b want 0", stall); end
        tick;
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL lu_a_sel: got %b want 00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL lu_b_sel: got %b want 00", fwd_b_sel); end
`endif
    endtask

    task automatic test_priority;
        do_reset;
        set_id(1, 1, 1, 0, 2, 1, 3, 1);
        tick;
        set_id(1, 1, 1, 0, 4, 1, 5, 1);
        tick;
        set_id(1, 2, 1, 0, 1, 1, 6, 1);
`ifdef FORWARDING_EN
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL prio_stall: got %b want 0", stall); end
        tick;
        checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL prio_a_sel: got %b want 01", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL prio_b_sel: got %b want 00", fwd_b_sel); end
`else
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL prio_stall1: got %b want 1", stall); end
        tick;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL prio_stall2: got %b want 1", stall); end
        tick;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL prio_stall3: got %b want 0", stall); end
`endif
    endtask

    task automatic test_xzr_unused;
        do_reset;
        set_id(1, 31, 1, 0, 2, 1, 3, 1);
        tick;
        set_id(1, 2, 1, 0, 31, 1, 31, 1);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL xzr_stall: got %b want 0", stall); end
        tick;
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL xzr_a_sel: got %b want 00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL xzr_b_sel: got %b want 00", fwd_b_sel); end
        set_id(1, 9, 1, 0, 2, 0, 2, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_stall: got %b want 0", stall); end
        tick;
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL unused_a_sel: got %b want 00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL unused_b_sel: got %b want 00", fwd_b_sel); end
    endtask

    task automatic test_mem_freeze;
        do_reset;
`ifdef FORWARDING_EN
        set_id(1, 2, 1, 0, 3, 1, 4, 1);
        tick;
        set_id(1, 7, 1, 1, 2, 1, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL frz_ldr_stall: got %b want 0", stall); end
        tick;
        checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL frz_ldr_a_sel: got %b want 01", fwd_a_sel); end
        set_id(1, 8, 1, 0, 7, 1, 3, 1);
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL frz_stall[%0d]: got %b want 1", i, stall); end
            checks++; if (flush_ex !== 1'b0) begin errors++; $display("FAIL frz_flush[%0d]: got %b want 0", i, flush_ex); end
            checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL frz_a_hold[%0d]: got %b want 01", i, fwd_a_sel); end
            tick;
        end
        mem_ready = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL frz_rel_stall: got %b want 1", stall); end
        checks++; if (flush_ex !== 1'b1) begin errors++; $display("FAIL frz_rel_flush: got %b want 1", flush_ex); end
        tick;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL frz_after_stall: got %b want 0", stall); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL frz_bubble_sel: got %b want 00", fwd_a_sel); end
        tick;
        checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL frz_a_sel: got %b want 10", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL frz_b_sel: got %b want 00", fwd_b_sel); end
`else
        set_id(1, 1, 1, 0, 2, 1, 3, 1);
        tick;
        set_id(1, 2, 1, 0, 1, 1, 3, 1);
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL frz_stall[%0d]: got %b want 1", i, stall); end
            checks++; if (flush_ex !== 1'b0) begin errors++; $display("FAIL frz_flush[%0d]: got %b want 0", i, flush_ex); end
            tick;
        end
        mem_ready = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL frz_rel_stall1: got %b want 1", stall); end
        checks++; if (flush_ex !== 1'b1) begin errors++; $display("FAIL frz_rel_flush1: got %b want 1", flush_ex); end
        tick;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL frz_rel_stall2: got %b want 1", stall); end
        tick;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL frz_rel_stall3: got %b want 0", stall); end
        checks++; if (flush_ex !== 1'b0) begin errors++; $display("FAIL frz_rel_flush3: got %b want 0", flush_ex); end
`endif
    endtask

    task automatic test_reset_mid_stall;
        do_reset;
`ifdef FORWARDING_EN
        set_id(1, 2, 1, 0, 3, 1, 4, 1);
        tick;
        set_id(1, 1, 1, 1, 2, 1, 0, 0);
        tick;
        checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL rms_pre_a_sel: got %b want 01", fwd_a_sel); end
`else
        set_id(1, 1, 1, 1, 3, 1, 0, 0);
        tick;
`endif
        set_id(1, 8, 1, 0, 1, 1, 1, 1);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_pre_stall: got %b want 1", stall); end
        rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_rst_stall: got %b want 0", stall); end
        checks++; if (flush_ex !== 1'b0) begin errors++; $display("FAIL rms_rst_flush: got %b want 0", flush_ex); end
        tick;
        rst = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_stall: got %b want 0", stall); end
        checks++; if (flush_ex !== 1'b0) begin errors++; $display("FAIL rms_flush: got %b want 0", flush_ex); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL rms_a_sel: got %b want 00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL rms_b_sel: got %b want 00", fwd_b_sel); end
        tick;
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL rms_next_a_sel: got %b want 00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL rms_next_b_sel: got %b want 00", fwd_b_sel); end
    endtask

    initial begin
        rst        = 1'b1;
        mem_ready  = 1'b1;
        id_valid   = 1'b0;
        id_rn      = '0;
        id_rm      = '0;
        id_rn_used = 1'b0;
        id_rm_used = 1'b0;
        id_rd      = '0;
        id_wr_en   = 1'b0;
        id_is_load = 1'b0;
        test_reset;
        test_back_to_back;
        test_distance2;
        test_load_use;
        test_priority;
        test_xzr_unused;
        test_mem_freeze;
        test_reset_mid_stall;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
